// File: rtl/mips_multicycle_control_pkg.sv
// Shared constants and types for the multicycle MIPS control FSM:
// opcodes, state encodings, ALU/mux select codes and the control word.
package mips_ctrl_pkg;

  localparam int STATE_BITS = 4;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [STATE_BITS-1:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADDR  = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTE  = 4'd6,
    RTYPEWB  = 4'd7,
    BRANCH   = 4'd8,
    JUMP     = 4'd9,
    ADDI_EX  = 4'd10,
    ADDI_WB  = 4'd11
  } state_e;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG      = 2'b00;
  localparam logic [1:0] SRCB_FOUR     = 2'b01;
  localparam logic [1:0] SRCB_IMM      = 2'b10;
  localparam logic [1:0] SRCB_IMM_SHL2 = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef struct packed {
    logic [1:0] aluOp;
    logic [1:0] aluSrcB;
    logic [1:0] pcSource;
    logic       regDst;
    logic       memtoReg;
    logic       memRead;
    logic       memWrite;
    logic       iorD;
    logic       regWrite;
    logic       irWrite;
    logic       pcWrite;
    logic       pcWriteCond;
    logic       aluSrcA;
    logic       instrDone;
  } ctrl_t;

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Control bundle between the multicycle control FSM (master) and the
// datapath (slave): opcode flows up, every control strobe flows down.
interface mips_ctrl_if #(parameter int STATE_W = 4);
  logic [5:0]         opcode;
  logic [1:0]         ALUOp;
  logic [1:0]         ALUSrcB;
  logic [1:0]         PCSource;
  logic               RegDst;
  logic               MemtoReg;
  logic               MemRead;
  logic               MemWrite;
  logic               IorD;
  logic               RegWrite;
  logic               IRWrite;
  logic               PCWrite;
  logic               PCWriteCond;
  logic               ALUSrcA;
  logic [STATE_W-1:0] state_out;
  logic               instr_done;
  logic               illegal_op;

  modport master (
    input  opcode,
    output ALUOp, ALUSrcB, PCSource, RegDst, MemtoReg, MemRead, MemWrite,
           IorD, RegWrite, IRWrite, PCWrite, PCWriteCond, ALUSrcA,
           state_out, instr_done, illegal_op
  );

  modport slave (
    output opcode,
    input  ALUOp, ALUSrcB, PCSource, RegDst, MemtoReg, MemRead, MemWrite,
           IorD, RegWrite, IRWrite, PCWrite, PCWriteCond, ALUSrcA,
           state_out, instr_done, illegal_op
  );
endinterface

// File: rtl/mips_multicycle_control_outputs.sv
// Pure state-to-control decode for the multicycle control FSM.
// Outputs depend on the state register and reset only, never on opcode.
// Define MIPS_CTRL_ADDI_EN to decode the ADDI execute/writeback states.
module mips_ctrl_outputs
  import mips_ctrl_pkg::*;
(
  input  state_e state_i,
  input  logic   reset_i,
  output ctrl_t  ctrl_o
);

  // Moore decode: every strobe defaults low, reset forces the whole word low
  always_comb begin
    ctrl_o = '0;
    if (!reset_i) begin
      case (state_i)
        FETCH: begin
          ctrl_o.memRead = 1'b1;
          ctrl_o.irWrite = 1'b1;
          ctrl_o.pcWrite = 1'b1;
          ctrl_o.aluSrcB = SRCB_FOUR;
          ctrl_o.aluOp   = ALU_ADD;
          ctrl_o.pcSource = PC_ALU;
        end
        DECODE: begin
          ctrl_o.aluSrcB = SRCB_IMM_SHL2;
          ctrl_o.aluOp   = ALU_ADD;
        end
        MEMADDR: begin
          ctrl_o.aluSrcA = 1'b1;
          ctrl_o.aluSrcB = SRCB_IMM;
          ctrl_o.aluOp   = ALU_ADD;
        end
        MEMREAD: begin
          ctrl_o.memRead = 1'b1;
          ctrl_o.iorD    = 1'b1;
        end
        MEMWB: begin
          ctrl_o.regWrite  = 1'b1;
          ctrl_o.memtoReg  = 1'b1;
          ctrl_o.instrDone = 1'b1;
        end
        MEMWRITE: begin
          ctrl_o.memWrite  = 1'b1;
          ctrl_o.iorD      = 1'b1;
          ctrl_o.instrDone = 1'b1;
        end
        EXECUTE: begin
          ctrl_o.aluSrcA = 1'b1;
          ctrl_o.aluSrcB = SRCB_REG;
          ctrl_o.aluOp   = ALU_FUNCT;
        end
        RTYPEWB: begin
          ctrl_o.regWrite  = 1'b1;
          ctrl_o.regDst    = 1'b1;
          ctrl_o.instrDone = 1'b1;
        end
        BRANCH: begin
          ctrl_o.aluSrcA     = 1'b1;
          ctrl_o.aluSrcB     = SRCB_REG;
          ctrl_o.aluOp       = ALU_SUB;
          ctrl_o.pcWriteCond = 1'b1;
          ctrl_o.pcSource    = PC_ALUOUT;
          ctrl_o.instrDone   = 1'b1;
        end
        JUMP: begin
          ctrl_o.pcWrite   = 1'b1;
          ctrl_o.pcSource  = PC_JUMP;
          ctrl_o.instrDone = 1'b1;
        end
`ifdef MIPS_CTRL_ADDI_EN
        ADDI_EX: begin
          ctrl_o.aluSrcA = 1'b1;
          ctrl_o.aluSrcB = SRCB_IMM;
          ctrl_o.aluOp   = ALU_ADD;
        end
        ADDI_WB: begin
          ctrl_o.regWrite  = 1'b1;
          ctrl_o.instrDone = 1'b1;
        end
`endif
        default: ctrl_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/
// writeback and drives every datapath control through mips_ctrl_if.
// Define MIPS_CTRL_ADDI_EN to add the ADDI_EX/ADDI_WB path; without it
// opcode 001000 is reported as illegal.
module mips_multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int STATE_W = STATE_BITS
) (
  input  logic        clock,
  input  logic        reset,
  mips_ctrl_if.master ctrl
);

  state_e stateQ, stateD;
  logic   illegalQ, illegalD;
  ctrl_t  ctrlW;

  // State and sticky illegal-opcode flag; reset abandons any instruction
  always_ff @(posedge clock) begin
    if (reset) begin
      stateQ   <= FETCH;
      illegalQ <= 1'b0;
    end else begin
      stateQ   <= stateD;
      illegalQ <= illegalD;
    end
  end

  // Next-state: opcode steers DECODE and MEMADDR, everything else is fixed
  always_comb begin
    stateD   = FETCH;
    illegalD = illegalQ;
    case (stateQ)
      FETCH: stateD = DECODE;
      DECODE: begin
        case (ctrl.opcode)
          OP_LW, OP_SW: stateD = MEMADDR;
          OP_RTYPE:     stateD = EXECUTE;
          OP_BEQ:       stateD = BRANCH;
          OP_J:         stateD = JUMP;
`ifdef MIPS_CTRL_ADDI_EN
          OP_ADDI:      stateD = ADDI_EX;
`endif
          default: begin
            stateD   = FETCH;
            illegalD = 1'b1;
          end
        endcase
      end
      MEMADDR: begin
        if (ctrl.opcode == OP_LW) begin
          stateD = MEMREAD;
        end else if (ctrl.opcode == OP_SW) begin
          stateD = MEMWRITE;
        end else begin
          stateD = FETCH;
        end
      end
      MEMREAD: stateD = MEMWB;
      EXECUTE: stateD = RTYPEWB;
`ifdef MIPS_CTRL_ADDI_EN
      ADDI_EX: stateD = ADDI_WB;
`endif
      default: stateD = FETCH;
    endcase
  end

  mips_ctrl_outputs u_outputs (
    .state_i (stateQ),
    .reset_i (reset),
    .ctrl_o  (ctrlW)
  );

  assign ctrl.ALUOp       = ctrlW.aluOp;
  assign ctrl.ALUSrcB     = ctrlW.aluSrcB;
  assign ctrl.PCSource    = ctrlW.pcSource;
  assign ctrl.RegDst      = ctrlW.regDst;
  assign ctrl.MemtoReg    = ctrlW.memtoReg;
  assign ctrl.MemRead     = ctrlW.memRead;
  assign ctrl.MemWrite    = ctrlW.memWrite;
  assign ctrl.IorD        = ctrlW.iorD;
  assign ctrl.RegWrite    = ctrlW.regWrite;
  assign ctrl.IRWrite     = ctrlW.irWrite;
  assign ctrl.PCWrite     = ctrlW.pcWrite;
  assign ctrl.PCWriteCond = ctrlW.pcWriteCond;
  assign ctrl.ALUSrcA     = ctrlW.aluSrcA;
  assign ctrl.instr_done  = ctrlW.instrDone;
  assign ctrl.state_out   = reset ? '0 : STATE_W'(stateQ);
  assign ctrl.illegal_op  = illegalQ & ~reset;

endmodule
